datapath: RTL and testbench

DATAPATH -- requirements
Module: datapath

---
 rtl/datapath.sv | 156 +++++++++++++++
 tb/tb_datapath.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/datapath.sv
// Single-bus processor datapath: register file, special registers, priority-selected
// internal bus and a combinational ALU whose 64-bit result is captured in Z.
module datapath (
    input  logic        clock,
    input  logic        clear,
    input  logic        R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  logic        R8in, R9in, R10in, R11in, R12in, R13in, R14in, R15in,
    input  logic        HIin, LOin, PCin, IRin, Yin, Zin, MARin, MDRin,
    input  logic        R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  logic        R8out, R9out, R10out, R11out, R12out, R13out, R14out, R15out,
    input  logic        HIout, LOout, Zhighout, Zlowout, PCout, MDRout, InPortout, Cout,
    input  logic        IncPC, ADD, SUB, AND, OR, SHR, SHRA, SHL,
    input  logic        ROR, ROL, NEG, NOT, MUL, DIV,
    input  logic        Read,
    input  logic [31:0] Mdatain,
    output logic [31:0] R0, R1, R2, R3, R4, R5, R6, R7,
    output logic [31:0] R8, R9, R10, R11, R12, R13, R14, R15,
    output logic [31:0] HI, LO, PC_out, IR, MAR, Y,
    output logic [63:0] Z,
    output logic [31:0] BusMuxOut_signal
);

    logic [31:0] r_gpr [16];
    logic [31:0] r_hi, r_lo, r_pc, r_ir, r_mar, r_mdr, r_y;
    logic [63:0] r_z;

    logic [15:0] w_rin;
    logic [23:0] w_sel;
    logic [31:0] w_src [24];
    logic [31:0] w_bus;
    logic [63:0] w_alu;

    assign w_rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};

    // Bit position in w_sel is the bus priority: bit 0 (R0) wins over everything.
    assign w_sel = {Cout, InPortout, MDRout, PCout, Zlowout, Zhighout, LOout, HIout,
                    R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_src[i] = r_gpr[i];
        end
        w_src[16] = r_hi;
        w_src[17] = r_lo;
        w_src[18] = r_z[63:32];
        w_src[19] = r_z[31:0];
        w_src[20] = r_pc;
        w_src[21] = r_mdr;
        w_src[22] = '0;
        w_src[23] = {{13{r_ir[18]}}, r_ir[18:0]};
    end

    always_comb begin
        w_bus = '0;
        for (int i = 23; i >= 0; i--) begin
            if (w_sel[i]) begin
                w_bus = w_src[i];
            end
        end
    end

    logic [31:0] w_a, w_b;
    logic [4:0]  w_amt;
    logic [63:0] w_prod;
    logic [31:0] w_quo, w_rem;

    assign w_a    = r_y;
    assign w_b    = w_bus;
    assign w_amt  = w_bus[4:0];
    assign w_prod = {{32{w_a[31]}}, w_a} * {{32{w_b[31]}}, w_b};

    // Division by zero yields zero rather than whatever the operator would give.
    always_comb begin
        w_quo = '0;
        w_rem = '0;
        if (w_b != 32'd0) begin
            w_quo = $signed(w_a) / $signed(w_b);
            w_rem = $signed(w_a) % $signed(w_b);
        end
    end

    always_comb begin
        w_alu = '0;
        if (IncPC)     w_alu = {32'd0, w_b + 32'd1};
        else if (ADD)  w_alu = {32'd0, w_a + w_b};
        else if (SUB)  w_alu = {32'd0, w_a - w_b};
        else if (AND)  w_alu = {32'd0, w_a & w_b};
        else if (OR)   w_alu = {32'd0, w_a | w_b};
        else if (SHR)  w_alu = {32'd0, w_a >> w_amt};
        else if (SHRA) w_alu = {32'd0, 32'($signed(w_a) >>> w_amt)};
        else if (SHL)  w_alu = {32'd0, w_a << w_amt};
        else if (ROR)  w_alu = {32'd0, (w_a >> w_amt) | (w_a << (6'd32 - {1'b0, w_amt}))};
        else if (ROL)  w_alu = {32'd0, (w_a << w_amt) | (w_a >> (6'd32 - {1'b0, w_amt}))};
        else if (NEG)  w_alu = {32'd0, 32'd0 - w_b};
        else if (NOT)  w_alu = {32'd0, ~w_b};
        else if (MUL)  w_alu = w_prod;
        else if (DIV)  w_alu = {w_rem, w_quo};
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) begin
                r_gpr[i] <= '0;
            end
            r_hi  <= '0;
            r_lo  <= '0;
            r_pc  <= '0;
            r_ir  <= '0;
            r_mar <= '0;
            r_mdr <= '0;
            r_y   <= '0;
            r_z   <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (w_rin[i]) r_gpr[i] <= w_bus;
            end
            if (HIin)  r_hi  <= w_bus;
            if (LOin)  r_lo  <= w_bus;
            if (PCin)  r_pc  <= w_bus;
            if (IRin)  r_ir  <= w_bus;
            if (MARin) r_mar <= w_bus;
            if (Yin)   r_y   <= w_bus;
            if (MDRin) r_mdr <= Read ? Mdatain : w_bus;
            if (Zin)   r_z   <= w_alu;
        end
    end

    assign R0  = r_gpr[0];
    assign R1  = r_gpr[1];
    assign R2  = r_gpr[2];
    assign R3  = r_gpr[3];
    assign R4  = r_gpr[4];
    assign R5  = r_gpr[5];
    assign R6  = r_gpr[6];
    assign R7  = r_gpr[7];
    assign R8  = r_gpr[8];
    assign R9  = r_gpr[9];
    assign R10 = r_gpr[10];
    assign R11 = r_gpr[11];
    assign R12 = r_gpr[12];
    assign R13 = r_gpr[13];
    assign R14 = r_gpr[14];
    assign R15 = r_gpr[15];

    assign HI               = r_hi;
    assign LO               = r_lo;
    assign PC_out           = r_pc;
    assign IR               = r_ir;
    assign MAR              = r_mar;
    assign Y                = r_y;
    assign Z                = r_z;
    assign BusMuxOut_signal = w_bus;

endmodule

// File: tb/tb_datapath.sv
// Random and directed bench for datapath, checked every cycle against a behavioural model.
module tb_datapath;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        clear;
    logic [23:0] ld;     // 0-15 Rn, 16 HI, 17 LO, 18 PC, 19 IR, 20 Y, 21 Z, 22 MAR, 23 MDR
    logic [23:0] src;    // 0-15 Rn, 16 HI, 17 LO, 18 Zhigh, 19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C
    logic [13:0] alu;    // IncPC ADD SUB AND OR SHR SHRA SHL ROR ROL NEG NOT MUL DIV
    logic        rd;
    logic [31:0] mdat;

    logic [31:0] o_r [16];
    logic [31:0] o_hi, o_lo, o_pc, o_ir, o_mar, o_y, o_bus;
    logic [63:0] o_z;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    datapath dut (
        .clock(clock), .clear(clear),
        .R0in(ld[0]), .R1in(ld[1]), .R2in(ld[2]), .R3in(ld[3]), .R4in(ld[4]), .R5in(ld[5]),
        .R6in(ld[6]), .R7in(ld[7]), .R8in(ld[8]), .R9in(ld[9]), .R10in(ld[10]), .R11in(ld[11]),
        .R12in(ld[12]), .R13in(ld[13]), .R14in(ld[14]), .R15in(ld[15]),
        .HIin(ld[16]), .LOin(ld[17]), .PCin(ld[18]), .IRin(ld[19]), .Yin(ld[20]), .Zin(ld[21]),
        .MARin(ld[22]), .MDRin(ld[23]),
        .R0out(src[0]), .R1out(src[1]), .R2out(src[2]), .R3out(src[3]), .R4out(src[4]),
        .R5out(src[5]), .R6out(src[6]), .R7out(src[7]), .R8out(src[8]), .R9out(src[9]),
        .R10out(src[10]), .R11out(src[11]), .R12out(src[12]), .R13out(src[13]),
        .R14out(src[14]), .R15out(src[15]),
        .HIout(src[16]), .LOout(src[17]), .Zhighout(src[18]), .Zlowout(src[19]), .PCout(src[20]),
        .MDRout(src[21]), .InPortout(src[22]), .Cout(src[23]),
        .IncPC(alu[0]), .ADD(alu[1]), .SUB(alu[2]), .AND(alu[3]), .OR(alu[4]), .SHR(alu[5]),
        .SHRA(alu[6]), .SHL(alu[7]), .ROR(alu[8]), .ROL(alu[9]), .NEG(alu[10]), .NOT(alu[11]),
        .MUL(alu[12]), .DIV(alu[13]),
        .Read(rd), .Mdatain(mdat),
        .R0(o_r[0]), .R1(o_r[1]), .R2(o_r[2]), .R3(o_r[3]), .R4(o_r[4]), .R5(o_r[5]),
        .R6(o_r[6]), .R7(o_r[7]), .R8(o_r[8]), .R9(o_r[9]), .R10(o_r[10]), .R11(o_r[11]),
        .R12(o_r[12]), .R13(o_r[13]), .R14(o_r[14]), .R15(o_r[15]),
        .HI(o_hi), .LO(o_lo), .PC_out(o_pc), .IR(o_ir), .MAR(o_mar), .Y(o_y), .Z(o_z),
        .BusMuxOut_signal(o_bus)
    );

    // ---------------- behavioural model ----------------
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_pc, m_ir, m_mar, m_mdr, m_y;
    logic [63:0] m_z;

    function automatic logic [31:0] m_src(input int i);
        if (i < 16) return m_r[i];
        case (i)
            16: return m_hi;
            17: return m_lo;
            18: return m_z[63:32];
            19: return m_z[31:0];
            20: return m_pc;
            21: return m_mdr;
            23: return m_ir[18] ? (32'hFFF80000 | m_ir[18:0]) : {13'd0, m_ir[18:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_bus();
        for (int i = 0; i < 24; i++) begin
            if (src[i]) return m_src(i);
        end
        return 32'd0;
    endfunction

    function automatic logic [63:0] m_alu(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        logic [31:0] ma, mb, q, r;
        logic [63:0] p;
        int n;
        n = int'(b[4:0]);
        t = a;
        if (alu[0]) return {32'd0, b + 32'd1};
        if (alu[1]) return {32'd0, a + b};
        if (alu[2]) return {32'd0, a - b};
        if (alu[3]) return {32'd0, a & b};
        if (alu[4]) return {32'd0, a | b};
        if (alu[5]) return {32'd0, a >> n};
        if (alu[6]) begin
            for (int k = 0; k < n; k++) t = {t[31], t[31:1]};
            return {32'd0, t};
        end
        if (alu[7]) return {32'd0, a << n};
        if (alu[8]) begin
            for (int k = 0; k < n; k++) t = {t[0], t[31:1]};
            return {32'd0, t};
        end
        if (alu[9]) begin
            for (int k = 0; k < n; k++) t = {t[30:0], t[31]};
            return {32'd0, t};
        end
        if (alu[10]) return {32'd0, ~b + 32'd1};
        if (alu[11]) return {32'd0, ~b};
        ma = a[31] ? (~a + 32'd1) : a;
        mb = b[31] ? (~b + 32'd1) : b;
        if (alu[12]) begin
            p = {32'd0, ma} * {32'd0, mb};
            return (a[31] ^ b[31]) ? (~p + 64'd1) : p;
        end
        if (alu[13]) begin
            if (b == 32'd0) return 64'd0;
            q = ma / mb;
            r = ma % mb;
            if (a[31] ^ b[31]) q = ~q + 32'd1;
            if (a[31]) r = ~r + 32'd1;
            return {r, q};
        end
        return 64'd0;
    endfunction

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            for (int i = 0; i < 16; i++) m_r[i] <= 32'd0;
            m_hi <= 0; m_lo <= 0; m_pc <= 0; m_ir <= 0;
            m_mar <= 0; m_mdr <= 0; m_y <= 0; m_z <= 0;
        end else begin
            for (int i = 0; i < 16; i++) if (ld[i]) m_r[i] <= m_bus();
            if (ld[16]) m_hi  <= m_bus();
            if (ld[17]) m_lo  <= m_bus();
            if (ld[18]) m_pc  <= m_bus();
            if (ld[19]) m_ir  <= m_bus();
            if (ld[20]) m_y   <= m_bus();
            if (ld[21]) m_z   <= m_alu(m_y, m_bus());
            if (ld[22]) m_mar <= m_bus();
            if (ld[23]) m_mdr <= rd ? mdat : m_bus();
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every cycle, compare all visible state and the bus against the model.
    always @(negedge clock) begin
        if (check_en) begin
            for (int i = 0; i < 16; i++) chk($sformatf("R%0d", i), {32'd0, o_r[i]}, {32'd0, m_r[i]});
            chk("HI", {32'd0, o_hi}, {32'd0, m_hi});
            chk("LO", {32'd0, o_lo}, {32'd0, m_lo});
            chk("PC", {32'd0, o_pc}, {32'd0, m_pc});
            chk("IR", {32'd0, o_ir}, {32'd0, m_ir});
            chk("MAR", {32'd0, o_mar}, {32'd0, m_mar});
            chk("Y", {32'd0, o_y}, {32'd0, m_y});
            chk("Z", o_z, m_z);
            chk("bus", {32'd0, o_bus}, {32'd0, m_bus()});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        ld = '0; src = '0; alu = '0; rd = 1'b0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic mdr_load(input logic [31:0] v);
        idle(); rd = 1'b1; mdat = v; ld[23] = 1'b1; step(); idle();
    endtask

    task automatic y_load(input logic [31:0] v);
        mdr_load(v); src[21] = 1'b1; ld[20] = 1'b1; step(); idle();
    endtask

    task automatic alu_op(input int op);
        idle(); src[21] = 1'b1; alu[op] = 1'b1; ld[21] = 1'b1; step(); idle();
    endtask

    initial begin
        clear = 1'b0;
        mdat  = 32'd0;
        idle();
        #2;
        chk("rst_R0", {32'd0, o_r[0]}, 64'd0);
        chk("rst_PC", {32'd0, o_pc}, 64'd0);
        chk("rst_Z", o_z, 64'd0);
        chk("rst_bus", {32'd0, o_bus}, 64'd0);
        #10 clear = 1'b1;
        check_en = 1'b1;
        step();

        // rotate left by 8 through R0/R4/Y/Z/R7
        mdr_load(32'hABCD1234); src[21] = 1; ld[0] = 1; step(); idle();
        mdr_load(32'd8);        src[21] = 1; ld[4] = 1; step(); idle();
        src[0] = 1; ld[20] = 1; step(); idle();
        src[4] = 1; alu[9] = 1; ld[21] = 1; step(); idle();
        src[19] = 1; ld[7] = 1; step(); idle();
        chk("rol_R7", {32'd0, o_r[7]}, 64'h00000000CD1234AB);

        // bus priority and idle bus
        src[0] = 1; src[21] = 1; #1;
        chk("prio_R0_over_MDR", {32'd0, o_bus}, 64'h00000000ABCD1234);
        idle(); src[21] = 1; src[23] = 1; #1;
        chk("prio_MDR_over_C", {32'd0, o_bus}, 64'd8);
        idle(); #1;
        chk("bus_none", {32'd0, o_bus}, 64'd0);

        // instruction fetch
        src[20] = 1; ld[22] = 1; alu[0] = 1; ld[21] = 1; step(); idle();
        src[19] = 1; ld[18] = 1; rd = 1; mdat = 32'h08704000; ld[23] = 1; step(); idle();
        src[21] = 1; ld[19] = 1; step(); idle();
        chk("fetch_MAR", {32'd0, o_mar}, 64'd0);
        chk("fetch_PC", {32'd0, o_pc}, 64'd1);
        chk("fetch_IR", {32'd0, o_ir}, 64'h0000000008704000);
        src[23] = 1; #1;
        chk("cout_pos", {32'd0, o_bus}, 64'h0000000000004000);
        mdr_load(32'h00040000); src[21] = 1; ld[19] = 1; step(); idle();
        src[23] = 1; #1;
        chk("cout_neg", {32'd0, o_bus}, 64'h00000000FFFC0000);
        idle();

        // signed multiply
        y_load(32'hFFFFFFFE); mdr_load(32'd3); alu_op(12);
        chk("mul_Z", o_z, 64'hFFFFFFFFFFFFFFFA);
        src[18] = 1; ld[16] = 1; step(); idle();
        src[19] = 1; ld[17] = 1; step(); idle();
        chk("mul_HI", {32'd0, o_hi}, 64'h00000000FFFFFFFF);
        chk("mul_LO", {32'd0, o_lo}, 64'h00000000FFFFFFFA);

        // divide, divide by zero, arithmetic shift
        y_load(32'hFFFFFFF9); mdr_load(32'd2); alu_op(13);
        chk("div_Z", o_z, 64'hFFFFFFFFFFFFFFFD);
        mdr_load(32'd0); alu_op(13);
        chk("div0_Z", o_z, 64'd0);
        y_load(32'h80000000); mdr_load(32'd4); alu_op(6);
        chk("shra_Z", o_z, 64'h00000000F8000000);

        // ALU select priority and no-op
        y_load(32'd10); mdr_load(32'd3);
        idle(); src[21] = 1; alu[1] = 1; alu[2] = 1; alu[12] = 1; ld[21] = 1; step(); idle();
        chk("alu_prio_add", o_z, 64'd13);
        idle(); src[21] = 1; ld[21] = 1; step(); idle();
        chk("alu_none", o_z, 64'd0);

        // asynchronous reset mid-cycle, then held across edges
        mdr_load(32'h55AA55AA);
        src[21] = 1; ld = 24'h7FFFFF; alu[11] = 1; step(); idle();
        chk("pre_rst_R5", {32'd0, o_r[5]}, 64'h0000000055AA55AA);
        chk("pre_rst_Z", o_z, 64'h00000000AA55AA55);
        #2 clear = 1'b0;
        src[21] = 1; #1;
        for (int i = 0; i < 16; i++) chk($sformatf("async_R%0d", i), {32'd0, o_r[i]}, 64'd0);
        chk("async_HI", {32'd0, o_hi}, 64'd0);
        chk("async_LO", {32'd0, o_lo}, 64'd0);
        chk("async_PC", {32'd0, o_pc}, 64'd0);
        chk("async_IR", {32'd0, o_ir}, 64'd0);
        chk("async_MAR", {32'd0, o_mar}, 64'd0);
        chk("async_Y", {32'd0, o_y}, 64'd0);
        chk("async_Z", o_z, 64'd0);
        chk("async_MDR_bus", {32'd0, o_bus}, 64'd0);
        ld = 24'hFFFFFF; rd = 1; mdat = 32'hFFFFFFFF; alu[11] = 1;
        step(); step();
        chk("held_R3", {32'd0, o_r[3]}, 64'd0);
        #3 clear = 1'b1;
        idle(); mdr_load(32'h12345678);
        src[21] = 1; ld[3] = 1; step(); idle();
        chk("resume_R3", {32'd0, o_r[3]}, 64'h0000000012345678);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            int mode;
            ld = 24'($urandom & $urandom);
            mode = $urandom_range(0, 3);
            src = (mode == 0) ? 24'd0 : (mode == 3) ? 24'($urandom & $urandom)
                                      : 24'(1) << $urandom_range(0, 23);
            mode = $urandom_range(0, 3);
            alu = (mode == 0) ? 14'd0 : (mode == 3) ? 14'($urandom & $urandom)
                                      : 14'(1) << $urandom_range(0, 13);
            rd = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       mdat = 32'($urandom_range(0, 40));
                1:       mdat = 32'd0 - 32'($urandom_range(1, 40));
                default: mdat = $urandom;
            endcase
            step();
        end
        idle();
        step();
        check_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
